// File: rtl/image_window_ctrl.sv
// Four round-robin line memories feeding a 3x3 window generator.
// A read burst of LINE_WIDTH-2 windows starts whenever three complete lines are buffered.
module image_window_ctrl #(
  parameter int LINE_WIDTH = 512,
  parameter int PIXEL_W    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [PIXEL_W-1:0]   i_pixel_data,
  input  logic                 i_pixel_data_valid,
  output logic [9*PIXEL_W-1:0] o_window,
  output logic                 o_window_valid,
  output logic                 o_intr
);

  localparam int COL_W = $clog2(LINE_WIDTH);
  localparam int CNT_W = $clog2(4 * LINE_WIDTH) + 1;

  localparam logic [COL_W-1:0] LAST_WR_COL = COL_W'(LINE_WIDTH - 1);
  localparam logic [COL_W-1:0] LAST_RD_COL = COL_W'(LINE_WIDTH - 3);
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(4 * LINE_WIDTH);
  localparam logic [CNT_W-1:0] CNT_READY   = CNT_W'(3 * LINE_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LINE    = CNT_W'(LINE_WIDTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } rd_state_t;

  // Handshake: the stream has no backpressure. A pixel is offered when
  // i_pixel_data_valid is high; it is taken unless all four lines are
  // buffered and no line is released in that same cycle, in which case it
  // is dropped. o_window is new in every cycle o_window_valid is high.

  logic [PIXEL_W-1:0] lb [0:3][0:LINE_WIDTH-1];

  logic [1:0]         wr_sel;
  logic [COL_W-1:0]   wr_col;
  logic [CNT_W-1:0]   total_cnt;
  logic [1:0]         rd_sel;
  logic [COL_W-1:0]   rd_col;
  rd_state_t          rd_state;
  rd_state_t          rd_state_nxt;
  logic               rd_issue;
  logic               rd_start;
  logic               line_release;
  logic               wr_accept;
  logic [9*PIXEL_W-1:0] win_nxt;

  assign line_release = rd_issue && (rd_col == LAST_RD_COL);
  assign wr_accept    = i_pixel_data_valid && ((total_cnt != CNT_FULL) || line_release);

  // Line memory contents are not reset.
  always_ff @(posedge i_clk) begin
    if (wr_accept) lb[wr_sel][wr_col] <= i_pixel_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_sel <= '0;
      wr_col <= '0;
    end else if (wr_accept) begin
      wr_col <= wr_col + COL_W'(1);
      if (wr_col == LAST_WR_COL) wr_sel <= wr_sel + 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      total_cnt <= '0;
    end else begin
      case ({wr_accept, line_release})
        2'b10:   total_cnt <= total_cnt + CNT_W'(1);
        2'b01:   total_cnt <= total_cnt - CNT_LINE;
        2'b11:   total_cnt <= total_cnt + CNT_W'(1) - CNT_LINE;
        default: total_cnt <= total_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rd_state <= S_IDLE;
    else          rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      S_IDLE:  if (total_cnt >= CNT_READY) rd_state_nxt = S_READ;
      S_READ:  if (rd_col == LAST_RD_COL)  rd_state_nxt = S_IDLE;
      default: rd_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_issue = (rd_state == S_READ);
    rd_start = (rd_state == S_IDLE) && (rd_state_nxt == S_READ);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_col <= '0;
      rd_sel <= '0;
    end else begin
      if (rd_start)      rd_col <= '0;
      else if (rd_issue) rd_col <= rd_col + COL_W'(1);
      if (line_release)  rd_sel <= rd_sel + 2'd1;
    end
  end

  // Row 0 (oldest line) lands in the top bits; within a row, column c is leftmost.
  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        win_nxt[(8 - 3*r - k)*PIXEL_W +: PIXEL_W] =
          lb[rd_sel + 2'(r)][rd_col + COL_W'(k)];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_window       <= '0;
      o_window_valid <= 1'b0;
      o_intr         <= 1'b0;
    end else begin
      if (rd_issue) o_window <= win_nxt;
      o_window_valid <= rd_issue;
      o_intr         <= line_release;
    end
  end

endmodule

// File: tb/tb_image_window_ctrl.sv
// Scoreboard bench for image_window_ctrl: line drivers push expected windows,
// a negedge monitor pops and compares them along with burst start cycles.
module tb_image_window_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pixel_data;
  logic        pixel_valid;
  logic [71:0] window;
  logic        window_valid;
  logic        intr;

  int checks_total = 0;
  int checks_pass  = 0;

  logic [72:0] exp_q[$];
  int          start_q[$];

  int cyc = 0;
  int cur_mode = 0;
  int n_lines = 0;
  int last_rel = 0;
  int win_idx = 0;
  int win_cnt = 0;
  int intr_cnt = 0;
  bit hand_chk = 0;
  bit prev_valid = 0;

  image_window_ctrl #(.LINE_WIDTH(512), .PIXEL_W(8)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_pixel_data       (pixel_data),
    .i_pixel_data_valid (pixel_valid),
    .o_window           (window),
    .o_window_valid     (window_valid),
    .o_intr             (intr)
  );

  // Clock and cycle counter
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] pix(input int n, input int c);
    if (cur_mode == 0) return 8'(16 * (n + 1));
    return 8'((c + n) % 256);
  endfunction

  task automatic push_burst(input int b, input int capture);
    logic [71:0] w;
    int first;
    for (int c = 0; c < 510; c++) begin
      w = '0;
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++)
          w[(8 - 3*r - k)*8 +: 8] = pix(b + r, c + k);
      exp_q.push_back({(c == 509), w});
    end
    first = ((capture > last_rel) ? capture : last_rel) + 2;
    start_q.push_back(first);
    last_rel = first + 509;
  endtask

  task automatic send_line(input bit gap);
    int cap;
    cap = 0;
    for (int c = 0; c < 512; c++) begin
      @(negedge clk);
      pixel_data  = pix(n_lines, c);
      pixel_valid = 1'b1;
      if (c == 511) cap = cyc + 1;
      if (gap) begin
        @(negedge clk);
        pixel_valid = 1'b0;
      end
    end
    n_lines++;
    if (n_lines >= 3) push_burst(n_lines - 3, cap);
  endtask

  task automatic send_lines(input int count, input bit gap);
    for (int l = 0; l < count; l++) send_line(gap);
    @(negedge clk);
    pixel_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pixel_valid = 1'b0;
    pixel_data = '0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    start_q.delete();
    n_lines = 0;
    last_rel = 0;
    win_cnt = 0;
    intr_cnt = 0;
    hand_chk = 0;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !window_valid) begin
        done = 1;
        break;
      end
    end
    chk({name, "_drained"}, 80'(done), 80'd1);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (window_valid) begin
      if (!prev_valid) begin
        win_idx = 0;
        if (start_q.size() == 0) chk("start_unexpected", 80'(cyc), 80'(-1));
        else chk("start_cycle", 80'(cyc), 80'(start_q.pop_front()));
      end
      if (exp_q.size() == 0) chk("window_unexpected", 80'({intr, window}), 80'(-1));
      else chk("window", 80'({intr, window}), 80'(exp_q.pop_front()));
      if (hand_chk) begin
        if (win_idx == 0)   chk("ramp_w0",   80'(window), 80'h000102010203020304);
        if (win_idx == 253) chk("ramp_w253", 80'(window), 80'hFDFEFFFEFF00FF0001);
        if (win_idx == 509) begin
          chk("ramp_w509", 80'(window), 80'hFDFEFFFEFF00FF0001);
          hand_chk = 0;
        end
      end
      if (intr) intr_cnt++;
      win_cnt++;
      win_idx++;
    end else begin
      chk("intr_idle", 80'(intr), 80'd0);
    end
    prev_valid = window_valid;
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    pixel_valid = 1'b0;
    pixel_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_window", 80'(window), 80'd0);
    chk("rst_valid",  80'(window_valid), 80'd0);
    chk("rst_intr",   80'(intr), 80'd0);
    rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    chk("idle_no_window", 80'(win_cnt), 80'd0);

    // Flat fill
    apply_reset();
    cur_mode = 0;
    send_lines(3, 0);
    drain("flat");
    chk("flat_windows", 80'(win_cnt), 80'd510);
    chk("flat_intr",    80'(intr_cnt), 80'd1);
    repeat (5) @(negedge clk);
    chk("flat_idle", 80'(window_valid), 80'd0);

    // Streaming ramp, four lines back-to-back
    apply_reset();
    cur_mode = 1;
    hand_chk = 1;
    fork
      send_lines(4, 0);
      begin
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
          @(negedge clk);
          if (intr) begin
            seen = 1;
            break;
          end
        end
        chk("intr_seen", 80'(seen), 80'd1);
        if (seen) chk("coincident_cnt", 80'(dut.total_cnt), 80'd1535);
      end
    join
    drain("stream");
    chk("stream_windows", 80'(win_cnt), 80'd1020);
    chk("stream_intr",    80'(intr_cnt), 80'd2);

    // Gapped ramp input
    apply_reset();
    cur_mode = 1;
    send_lines(3, 1);
    drain("gapped");
    chk("gapped_windows", 80'(win_cnt), 80'd510);

    // Mid-read reset
    apply_reset();
    cur_mode = 0;
    send_lines(3, 0);
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (window_valid && win_idx == 100) begin
        seen = 1;
        break;
      end
    end
    chk("midread_reached", 80'(seen), 80'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midread_valid",  80'(window_valid), 80'd0);
    chk("midread_window", 80'(window), 80'd0);
    chk("midread_intr",   80'(intr), 80'd0);
    apply_reset();
    cur_mode = 1;
    hand_chk = 1;
    send_lines(3, 0);
    drain("after_reset");
    chk("after_reset_windows", 80'(win_cnt), 80'd510);
    chk("queue_empty", 80'(exp_q.size() + start_q.size()), 80'd0);

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
